interrupt_ack_control: RTL and testbench

CPU-side acknowledge and in-service controller of the 8259 PIC. It consumes the one-hot winner from the priority resolver and drives INT to the CPU. It runs the two-pulse INTA sequence (8086 mode), owns the in-service register, and returns `in_service_register` and `priority_rotate` to the resolver. It also decodes end-of-interrupt commands and, optionally, rotates priority.

---
 rtl/interrupt_ack_control.sv | 171 +++++++++++++++++
 tb/tb_interrupt_ack_control.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/interrupt_ack_control.sv
// rtl/interrupt_ack_control.sv - 8259 INTA sequencer, in-service register and EOI handling (optional PIC_ROTATE_ON_EOI_EN)
module interrupt_ack_control (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] interrupt,
    input  logic       inta_n,
    input  logic [4:0] vector_base,
    input  logic       auto_eoi,
    input  logic       eoi_valid,
    input  logic       eoi_specific,
    input  logic [2:0] eoi_level,
    input  logic       eoi_rotate,
    output logic       int_out,
    output logic [7:0] in_service_register,
    output logic [2:0] priority_rotate,
    output logic [7:0] data_out,
    output logic       data_out_en
);

    typedef enum logic [1:0] {IDLE, WAIT_ACK1, WAIT_ACK2, DRIVE_VEC} state_t;

    state_t     state_q, state_d;
    logic       inta_prev_q;
    logic       int_out_q, int_out_d;
    logic [7:0] isr_q, isr_d;
    logic [2:0] rot_q, rot_d;
    logic [7:0] data_q, data_d;
    logic       en_q, en_d;
    logic [2:0] level_q, level_d;
    logic       spur_q, spur_d;

    logic       inta_fall, inta_rise;
    logic [2:0] irq_level;
    logic [7:0] eoi_clr;
    logic       eoi_hit;
    logic [2:0] eoi_clr_level;
    logic [2:0] scan_idx;
    logic [7:0] isr_set;
    logic [7:0] aeoi_clr;

    assign inta_fall = !inta_n && inta_prev_q;
    assign inta_rise = inta_n && !inta_prev_q;

    // Binary index of the (one-hot) winner from the resolver.
    always_comb begin
        irq_level = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (interrupt[i]) irq_level = 3'(i);
        end
    end

    // EOI decode: specific clears eoi_level, non-specific scans from rotate+1 down to rotate.
    always_comb begin
        eoi_clr       = 8'h00;
        eoi_hit       = 1'b0;
        eoi_clr_level = eoi_level;
        scan_idx      = 3'd0;
        if (eoi_valid) begin
            if (eoi_specific) begin
                eoi_hit = isr_q[eoi_level];
            end else begin
                // Scan lowest priority first so the highest-priority set bit is the last write.
                for (int k = 8; k >= 1; k--) begin
                    scan_idx = rot_q + 3'(k);
                    if (isr_q[scan_idx]) begin
                        eoi_hit       = 1'b1;
                        eoi_clr_level = scan_idx;
                    end
                end
            end
        end
        if (eoi_hit) eoi_clr[eoi_clr_level] = 1'b1;
    end

    // Acknowledge sequencer and next-state of ISR / rotation.
    always_comb begin
        state_d   = state_q;
        int_out_d = int_out_q;
        data_d    = data_q;
        en_d      = en_q;
        level_d   = level_q;
        spur_d    = spur_q;
        isr_set   = 8'h00;
        aeoi_clr  = 8'h00;
        rot_d     = rot_q;
        unique case (state_q)
            IDLE: begin
                if (interrupt != 8'h00) begin
                    int_out_d = 1'b1;
                    state_d   = WAIT_ACK1;
                end
            end
            WAIT_ACK1: begin
                if (inta_fall) begin
                    int_out_d = 1'b0;
                    state_d   = WAIT_ACK2;
                    if (interrupt != 8'h00) begin
                        level_d            = irq_level;
                        spur_d             = 1'b0;
                        isr_set[irq_level] = 1'b1;
                    end else begin
                        // Request withdrawn before the acknowledge: answer with IR7, ISR untouched.
                        level_d = 3'd7;
                        spur_d  = 1'b1;
                    end
                end
            end
            WAIT_ACK2: begin
                if (inta_fall) begin
                    data_d  = {vector_base, level_q};
                    en_d    = 1'b1;
                    state_d = DRIVE_VEC;
                end
            end
            DRIVE_VEC: begin
                if (inta_rise) begin
                    data_d  = 8'h00;
                    en_d    = 1'b0;
                    state_d = IDLE;
                    if (auto_eoi && !spur_q) aeoi_clr[level_q] = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
        // A set from ACK1 wins over a clear of the same bit.
        isr_d = (isr_q & ~(eoi_clr | aeoi_clr)) | isr_set;
`ifdef PIC_ROTATE_ON_EOI_EN
        if (eoi_rotate && ((aeoi_clr & isr_q) != 8'h00)) rot_d = level_q;
        if (eoi_rotate && eoi_hit) rot_d = eoi_clr_level;
`else
        rot_d = 3'b111;
`endif
    end

`ifndef PIC_ROTATE_ON_EOI_EN
    logic unused_eoi_rotate;
    assign unused_eoi_rotate = eoi_rotate;
`endif

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            inta_prev_q <= 1'b1;
            int_out_q   <= 1'b0;
            isr_q       <= 8'h00;
            rot_q       <= 3'b111;
            data_q      <= 8'h00;
            en_q        <= 1'b0;
            level_q     <= 3'd0;
            spur_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            inta_prev_q <= inta_n;
            int_out_q   <= int_out_d;
            isr_q       <= isr_d;
            rot_q       <= rot_d;
            data_q      <= data_d;
            en_q        <= en_d;
            level_q     <= level_d;
            spur_q      <= spur_d;
        end
    end

    assign int_out             = int_out_q;
    assign in_service_register = isr_q;
    assign priority_rotate     = rot_q;
    assign data_out            = data_q;
    assign data_out_en         = en_q;

endmodule

// File: tb/tb_interrupt_ack_control.sv
// tb/tb_interrupt_ack_control.sv - self-checking bench for interrupt_ack_control
module tb_interrupt_ack_control;

    logic       clk = 1'b0;
    logic       rst, inta_n, auto_eoi, eoi_valid, eoi_specific, eoi_rotate;
    logic [7:0] interrupt;
    logic [4:0] vector_base;
    logic [2:0] eoi_level;
    logic       int_out, data_out_en;
    logic [7:0] isr, data_out;
    logic [2:0] prot;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    interrupt_ack_control dut (
        .clk(clk), .rst(rst), .interrupt(interrupt), .inta_n(inta_n),
        .vector_base(vector_base), .auto_eoi(auto_eoi), .eoi_valid(eoi_valid),
        .eoi_specific(eoi_specific), .eoi_level(eoi_level), .eoi_rotate(eoi_rotate),
        .int_out(int_out), .in_service_register(isr), .priority_rotate(prot),
        .data_out(data_out), .data_out_en(data_out_en)
    );

    // Reference model: acknowledge progress counter plus ISR as a bit vector.
    bit       m_prev, m_int, m_en, m_spur;
    bit [7:0] m_isr, m_data;
    int       m_phase, m_level, m_rot;

    task automatic model_reset();
        m_prev = 1; m_int = 0; m_en = 0; m_spur = 0;
        m_isr = 0; m_data = 0; m_phase = 0; m_level = 0; m_rot = 7;
    endtask

    task automatic model_step();
        bit       fall, rise, ae_rot;
        bit [7:0] set_m, clr_m;
        int       clr_lvl;
        fall = !inta_n && m_prev;
        rise = inta_n && !m_prev;
        if (rst) begin
            model_reset();
            return;
        end
        set_m = 0; clr_m = 0; clr_lvl = -1; ae_rot = 0;
        if (eoi_valid) begin
            if (eoi_specific) begin
                if (m_isr[eoi_level]) clr_lvl = eoi_level;
            end else begin
                for (int p = 1; p <= 8; p++)
                    if (clr_lvl < 0 && m_isr[(m_rot + p) % 8]) clr_lvl = (m_rot + p) % 8;
            end
        end
        if (clr_lvl >= 0) clr_m[clr_lvl] = 1;
        case (m_phase)
            0: if (interrupt != 0) begin m_int = 1; m_phase = 1; end
            1: if (fall) begin
                m_int = 0; m_phase = 2;
                if (interrupt == 0) begin m_spur = 1; m_level = 7; end
                else begin m_spur = 0; m_level = $clog2(interrupt); set_m[m_level] = 1; end
            end
            2: if (fall) begin m_data = {vector_base, 3'(m_level)}; m_en = 1; m_phase = 3; end
            default: if (rise) begin
                m_en = 0; m_data = 0; m_phase = 0;
                if (auto_eoi && !m_spur) begin
                    if (m_isr[m_level]) ae_rot = 1;
                    clr_m[m_level] = 1;
                end
            end
        endcase
        m_isr = (m_isr & ~clr_m) | set_m;
`ifdef PIC_ROTATE_ON_EOI_EN
        if (eoi_rotate && ae_rot) m_rot = m_level;
        if (eoi_rotate && clr_lvl >= 0) m_rot = clr_lvl;
`endif
        m_prev = inta_n;
    endtask

    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic cycle(input string tag);
        model_step();
        @(posedge clk); #1;
        chk({tag, ".int_out"}, {7'd0, int_out}, {7'd0, m_int});
        chk({tag, ".isr"}, isr, m_isr);
        chk({tag, ".rotate"}, {5'd0, prot}, 8'(m_rot));
        chk({tag, ".data"}, data_out, m_data);
        chk({tag, ".data_en"}, {7'd0, data_out_en}, {7'd0, m_en});
    endtask

    task automatic idle_inputs();
        rst = 0; interrupt = 0; inta_n = 1; auto_eoi = 0; eoi_valid = 0;
        eoi_specific = 0; eoi_level = 0; eoi_rotate = 0;
    endtask

    task automatic ack(input logic [7:0] irq);
        interrupt = irq; inta_n = 1; cycle("ack_req");
        inta_n = 0; cycle("ack1");
        inta_n = 1; cycle("ack_gap");
        inta_n = 0; cycle("ack2");
        inta_n = 1; interrupt = 0; cycle("ack_rel");
    endtask

    typedef struct {
        bit       rst;
        bit [7:0] irq;
        bit       inta;
        bit       aeoi;
        bit       eoi_v;
        bit       eoi_s;
        bit [2:0] eoi_l;
        bit       e_int;
        bit [7:0] e_isr;
        bit [7:0] e_data;
        bit       e_en;
    } vec_t;

    vec_t tbl[$];

    initial begin
        model_reset();
        idle_inputs();
        vector_base = 5'b00001;
        //          rst irq   inta aeoi ev es el  int isr    data   en
        tbl.push_back('{1, 8'h00, 1, 0, 0, 0, 0, 0, 8'h00, 8'h00, 0});
        tbl.push_back('{0, 8'h04, 1, 0, 0, 0, 0, 1, 8'h00, 8'h00, 0});
        tbl.push_back('{0, 8'h04, 0, 0, 0, 0, 0, 0, 8'h04, 8'h00, 0});
        tbl.push_back('{0, 8'h04, 1, 0, 0, 0, 0, 0, 8'h04, 8'h00, 0});
        tbl.push_back('{0, 8'h04, 0, 0, 0, 0, 0, 0, 8'h04, 8'h0A, 1});
        tbl.push_back('{0, 8'h04, 1, 0, 0, 0, 0, 0, 8'h04, 8'h00, 0});
        tbl.push_back('{0, 8'h00, 1, 0, 1, 1, 2, 0, 8'h00, 8'h00, 0});
        tbl.push_back('{0, 8'h80, 1, 1, 0, 0, 0, 1, 8'h00, 8'h00, 0});
        tbl.push_back('{0, 8'h80, 0, 1, 0, 0, 0, 0, 8'h80, 8'h00, 0});
        tbl.push_back('{0, 8'h80, 1, 1, 0, 0, 0, 0, 8'h80, 8'h00, 0});
        tbl.push_back('{0, 8'h80, 0, 1, 0, 0, 0, 0, 8'h80, 8'h0F, 1});
        tbl.push_back('{0, 8'h00, 1, 1, 0, 0, 0, 0, 8'h00, 8'h00, 0});
        tbl.push_back('{0, 8'h02, 1, 0, 0, 0, 0, 1, 8'h00, 8'h00, 0});
        tbl.push_back('{0, 8'h00, 0, 0, 0, 0, 0, 0, 8'h00, 8'h00, 0});
        tbl.push_back('{0, 8'h00, 1, 0, 0, 0, 0, 0, 8'h00, 8'h00, 0});
        tbl.push_back('{0, 8'h00, 0, 0, 0, 0, 0, 0, 8'h00, 8'h0F, 1});
        tbl.push_back('{0, 8'h00, 0, 0, 0, 0, 0, 0, 8'h00, 8'h0F, 1});
        tbl.push_back('{0, 8'h00, 1, 0, 0, 0, 0, 0, 8'h00, 8'h00, 0});
        tbl.push_back('{0, 8'h00, 0, 0, 0, 0, 0, 0, 8'h00, 8'h00, 0});
        tbl.push_back('{0, 8'h00, 1, 0, 0, 0, 0, 0, 8'h00, 8'h00, 0});
        tbl.push_back('{0, 8'h08, 1, 0, 0, 0, 0, 1, 8'h00, 8'h00, 0});
        tbl.push_back('{0, 8'h08, 0, 0, 1, 1, 3, 0, 8'h08, 8'h00, 0});
        tbl.push_back('{0, 8'h08, 1, 0, 0, 0, 0, 0, 8'h08, 8'h00, 0});
        tbl.push_back('{0, 8'h08, 0, 0, 0, 0, 0, 0, 8'h08, 8'h0B, 1});
        tbl.push_back('{0, 8'h00, 1, 0, 0, 0, 0, 0, 8'h08, 8'h00, 0});
        tbl.push_back('{0, 8'h00, 1, 0, 1, 0, 0, 0, 8'h00, 8'h00, 0});

        foreach (tbl[i]) begin
            rst = tbl[i].rst; interrupt = tbl[i].irq; inta_n = tbl[i].inta;
            auto_eoi = tbl[i].aeoi; eoi_valid = tbl[i].eoi_v;
            eoi_specific = tbl[i].eoi_s; eoi_level = tbl[i].eoi_l;
            cycle($sformatf("row%0d", i));
            chk($sformatf("tbl%0d.int_out", i), {7'd0, int_out}, {7'd0, tbl[i].e_int});
            chk($sformatf("tbl%0d.isr", i), isr, tbl[i].e_isr);
            chk($sformatf("tbl%0d.data", i), data_out, tbl[i].e_data);
            chk($sformatf("tbl%0d.en", i), {7'd0, data_out_en}, {7'd0, tbl[i].e_en});
        end

        // Non-specific then specific EOI on ISR = 8'h12.
        idle_inputs();
        ack(8'h02);
        ack(8'h10);
        chk("nseoi.isr_before", isr, 8'h12);
        eoi_valid = 1; eoi_specific = 0; cycle("nseoi");
        chk("nseoi.isr_after", isr, 8'h10);
        eoi_specific = 1; eoi_level = 4; cycle("seoi");
        chk("seoi.isr_after", isr, 8'h00);
        idle_inputs();

        // Rotate-on-EOI request.
        ack(8'h08);
        eoi_valid = 1; eoi_specific = 0; eoi_rotate = 1; cycle("rot_eoi");
        chk("rot.isr", isr, 8'h00);
`ifdef PIC_ROTATE_ON_EOI_EN
        chk("rot.rotate", {5'd0, prot}, 8'h03);
`else
        chk("rot.rotate_fixed", {5'd0, prot}, 8'h07);
`endif
        idle_inputs();
        rst = 1; cycle("rot_reset");
        rst = 0;

        // Reset while waiting for the second INTA pulse.
        interrupt = 8'h01; cycle("rw_req");
        inta_n = 0; cycle("rw_ack1");
        chk("rw.isr_set", isr, 8'h01);
        inta_n = 1; rst = 1; cycle("rw_rst");
        chk("rw.int_out", {7'd0, int_out}, 8'h00);
        chk("rw.isr", isr, 8'h00);
        chk("rw.rotate", {5'd0, prot}, 8'h07);
        chk("rw.data", data_out, 8'h00);
        chk("rw.en", {7'd0, data_out_en}, 8'h00);
        rst = 0; interrupt = 0;
        for (int i = 0; i < 4; i++) begin
            inta_n = (i % 2 == 1);
            cycle("rw_post");
            chk("rw_post.en", {7'd0, data_out_en}, 8'h00);
            chk("rw_post.data", data_out, 8'h00);
        end

        // Randomized traffic against the model.
        idle_inputs();
        for (int n = 0; n < 3000; n++) begin
            rst = ($urandom_range(0, 199) == 0);
            if ($urandom_range(0, 4) == 0)
                interrupt = ($urandom_range(0, 2) == 0) ? 8'h00 : 8'(1 << $urandom_range(0, 7));
            inta_n = ($urandom_range(0, 9) >= 3);
            if ($urandom_range(0, 49) == 0) auto_eoi = $urandom_range(0, 1);
            if ($urandom_range(0, 99) == 0) vector_base = 5'($urandom);
            eoi_valid    = ($urandom_range(0, 6) == 0);
            eoi_specific = $urandom_range(0, 1);
            eoi_level    = 3'($urandom);
            eoi_rotate   = $urandom_range(0, 1);
            cycle("rand");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
